// File: rtl/helper_axis_pkg.sv
`default_nettype none
// ============================================================================
// Module      : helper_axis_pkg
// Description : Shared constants and types for the AXI-Stream pattern
//               generator: data mode selectors, FSM state type and a
//               saturating counter helper.
// Revision    : 1.0 - initial release
// ============================================================================
package helper_axis_pkg;

  localparam int MODE_COUNT = 0;
  localparam int MODE_STEP  = 1;
  localparam int MODE_LFSR  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } gen_state_t;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/helper_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : helper_lfsr
// Description : Fibonacci LFSR that shifts left and feeds the XOR of the
//               tapped bits into bit 0. Steps only when advance is high.
//               A zero seed is replaced by 1 so the register never locks up.
// Revision    : 1.0 - initial release
// ============================================================================
module helper_lfsr #(
  parameter int          DATA_WIDTH = 10,
  parameter logic [31:0] LFSR_TAPS  = 32'h240,
  parameter logic [31:0] LFSR_SEED  = 32'd1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  advance,
  output logic [DATA_WIDTH-1:0] state
);

  localparam logic [DATA_WIDTH-1:0] c_taps     = DATA_WIDTH'(LFSR_TAPS);
  localparam logic [DATA_WIDTH-1:0] c_seed_raw = DATA_WIDTH'(LFSR_SEED);
  localparam logic [DATA_WIDTH-1:0] c_seed     =
      (c_seed_raw == '0) ? DATA_WIDTH'(1) : c_seed_raw;

  logic [DATA_WIDTH-1:0] state_q;
  logic [DATA_WIDTH-1:0] state_d;

  // Next LFSR value: shift left, feedback parity enters at the bottom.
  always_comb begin
    state_d = state_q;
    if (advance) begin
      state_d = {state_q[DATA_WIDTH-2:0], ^(state_q & c_taps)};
    end
  end

  // State register, reloaded with the seed on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= c_seed;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule
`default_nettype wire

// File: rtl/helper_axis_pattern_generator.sv
`default_nettype none
// ============================================================================
// Module      : helper_axis_pattern_generator
// Description : AXI-Stream test-data source. Produces counter, stepped or
//               LFSR data, frames packets with output_last, throttles valid
//               with a cyclic duty pattern and optionally stops after a fixed
//               number of accepted beats. A raised valid is held, with data
//               and last frozen, until the sink accepts the beat.
// Revision    : 1.0 - initial release
// ============================================================================
module helper_axis_pattern_generator
  import helper_axis_pkg::*;
#(
  parameter int          DATA_WIDTH    = 10,
  parameter int          MODE          = 0,
  parameter int          START_AT      = 0,
  parameter int          END_AT        = 2**DATA_WIDTH - 1,
  parameter int          STEP          = 1,
  parameter logic [31:0] LFSR_SEED     = 32'd1,
  parameter logic [31:0] LFSR_TAPS     = 32'h240,
  parameter int          PACKET_LEN    = 0,
  parameter int          PATTERN_LEN   = 1,
  parameter logic [31:0] VALID_PATTERN = 32'd1,
  parameter logic [31:0] TOTAL_BEATS   = 32'd0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  output logic                  output_valid,
  output logic [DATA_WIDTH-1:0] output_data,
  output logic                  output_last,
  input  logic                  output_ready,
  output logic                  done,
  output logic [31:0]           beat_count
);

  localparam logic [4:0]  c_idx_last = 5'(PATTERN_LEN - 1);
  localparam logic [31:0] c_pkt_last = 32'(PACKET_LEN - 1);
  localparam logic        c_framed   = (PACKET_LEN != 0);

  gen_state_t  state_q, state_d;
  logic        valid_q, valid_d;
  logic [4:0]  idx_q,   idx_d;
  logic [31:0] pkt_q,   pkt_d;
  logic [31:0] cnt_q,   cnt_d;

  logic                  w_xfer;
  logic [DATA_WIDTH-1:0] w_data;

  assign w_xfer = valid_q & output_ready;

  // Control FSM: launch gating, pattern walk, framing and beat accounting.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    pkt_d   = pkt_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (w_xfer) begin
          cnt_d = sat_inc32(cnt_q);
          pkt_d = (pkt_q == c_pkt_last) ? 32'd0 : pkt_q + 32'd1;
        end
        if (w_xfer && (TOTAL_BEATS != 32'd0) && ((cnt_q + 32'd1) == TOTAL_BEATS)) begin
          state_d = DONE;
          valid_d = 1'b0;
        end else if (!valid_q || w_xfer) begin
          // Slot is free: the pattern decides whether a new beat goes out.
          if (enable) begin
            valid_d = VALID_PATTERN[idx_q];
            idx_d   = (idx_q == c_idx_last) ? 5'd0 : idx_q + 5'd1;
          end else begin
            valid_d = 1'b0;
          end
        end
      end
      DONE: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      idx_q   <= 5'd0;
      pkt_q   <= 32'd0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      pkt_q   <= pkt_d;
      cnt_q   <= cnt_d;
    end
  end

  generate
    if (MODE == MODE_LFSR) begin : g_lfsr
      helper_lfsr #(
        .DATA_WIDTH (DATA_WIDTH),
        .LFSR_TAPS  (LFSR_TAPS),
        .LFSR_SEED  (LFSR_SEED)
      ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .advance (w_xfer),
        .state   (w_data)
      );
    end else begin : g_count
      localparam logic [DATA_WIDTH-1:0] c_start = DATA_WIDTH'(START_AT);
      localparam logic [DATA_WIDTH-1:0] c_end   = DATA_WIDTH'(END_AT);
      localparam logic [DATA_WIDTH-1:0] c_step  =
          (MODE == MODE_STEP) ? DATA_WIDTH'(STEP) : DATA_WIDTH'(1);

      logic [DATA_WIDTH-1:0] data_q, data_d;

      // Advance on each accepted beat; wrap when the next step would pass END_AT.
      always_comb begin
        data_d = data_q;
        if (w_xfer) begin
          if ((data_q == c_end) || ((c_end - data_q) < c_step)) begin
            data_d = c_start;
          end else begin
            data_d = data_q + c_step;
          end
        end
      end

      // Data register, reloaded with the start value on reset.
      always_ff @(posedge clk) begin
        if (rst) begin
          data_q <= c_start;
        end else begin
          data_q <= data_d;
        end
      end

      assign w_data = data_q;
    end
  endgenerate

  assign output_valid = valid_q;
  assign output_data  = w_data;
  assign output_last  = valid_q & c_framed & (pkt_q == c_pkt_last);
  assign done         = (state_q == DONE);
  assign beat_count   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_helper_axis_pattern_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_helper_axis_pattern_generator
// Description : Four generator instances (counter with packets, stepped with
//               alternating duty, LFSR, bounded beat count) driven with
//               random ready/enable and compared every cycle against a
//               reference model built from the beat index of each transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_helper_axis_pattern_generator;

  localparam int W      = 10;
  localparam int NINST  = 4;
  localparam int CYCLES = 1600;

  typedef struct {
    int mode;
    int start;
    int endv;
    int step;
    int plen;
    int patlen;
    int pat;
    int total;
  } cfg_t;

  typedef struct {
    int phase;   // 0 waiting for enable, 1 streaming, 2 finished
    bit valid;
    int slot;    // pattern slot consulted at the next free slot
    int n;       // accepted beats since reset
  } mdl_t;

  logic         clk;
  logic         rst_v [NINST];
  logic         en_v  [NINST];
  logic         rdy_v [NINST];
  logic         vld_v [NINST];
  logic [W-1:0] dat_v [NINST];
  logic         lst_v [NINST];
  logic         dn_v  [NINST];
  logic [31:0]  bc_v  [NINST];

  cfg_t cfg [NINST];
  mdl_t mdl [NINST];
  int   lfsr_seq [4096];
  int   total;
  int   bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  helper_axis_pattern_generator #(
    .DATA_WIDTH(W), .MODE(0), .START_AT(3), .END_AT(6),
    .PACKET_LEN(4), .PATTERN_LEN(3), .VALID_PATTERN(32'b011)
  ) u_cnt (
    .clk(clk), .rst(rst_v[0]), .enable(en_v[0]), .output_valid(vld_v[0]),
    .output_data(dat_v[0]), .output_last(lst_v[0]), .output_ready(rdy_v[0]),
    .done(dn_v[0]), .beat_count(bc_v[0])
  );

  helper_axis_pattern_generator #(
    .DATA_WIDTH(W), .MODE(1), .START_AT(0), .END_AT(10), .STEP(3),
    .PACKET_LEN(4), .PATTERN_LEN(4), .VALID_PATTERN(32'b0101)
  ) u_step (
    .clk(clk), .rst(rst_v[1]), .enable(en_v[1]), .output_valid(vld_v[1]),
    .output_data(dat_v[1]), .output_last(lst_v[1]), .output_ready(rdy_v[1]),
    .done(dn_v[1]), .beat_count(bc_v[1])
  );

  helper_axis_pattern_generator #(
    .DATA_WIDTH(W), .MODE(2), .LFSR_SEED(32'd1), .LFSR_TAPS(32'h240)
  ) u_lfsr (
    .clk(clk), .rst(rst_v[2]), .enable(en_v[2]), .output_valid(vld_v[2]),
    .output_data(dat_v[2]), .output_last(lst_v[2]), .output_ready(rdy_v[2]),
    .done(dn_v[2]), .beat_count(bc_v[2])
  );

  helper_axis_pattern_generator #(
    .DATA_WIDTH(W), .MODE(0), .TOTAL_BEATS(32'd5)
  ) u_tot (
    .clk(clk), .rst(rst_v[3]), .enable(en_v[3]), .output_valid(vld_v[3]),
    .output_data(dat_v[3]), .output_last(lst_v[3]), .output_ready(rdy_v[3]),
    .done(dn_v[3]), .beat_count(bc_v[3])
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Value of the n-th beat, derived directly from the sequence definition.
  function automatic int exp_data(cfg_t c, int n);
    int period;
    if (c.mode == 2) return lfsr_seq[n % 4096];
    period = (c.endv - c.start) / c.step + 1;
    return c.start + c.step * (n % period);
  endfunction

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.phase = 0;
    m.valid = 1'b0;
    m.slot  = 0;
    m.n     = 0;
    return m;
  endfunction

  // One clock of the reference behaviour given the inputs sampled at that edge.
  function automatic mdl_t mdl_step(cfg_t c, mdl_t m, bit r, bit e, bit y);
    mdl_t nx;
    bit   accepted;
    if (r) return mdl_reset();
    nx = m;
    accepted = m.valid && y;
    if (m.phase == 0) begin
      if (e) nx.phase = 1;
    end else if (m.phase == 1) begin
      if (accepted) nx.n = m.n + 1;
      if (accepted && c.total != 0 && nx.n == c.total) begin
        nx.phase = 2;
        nx.valid = 1'b0;
      end else if (!m.valid || accepted) begin
        if (e) begin
          nx.valid = ((c.pat >> m.slot) & 1) != 0;
          nx.slot  = (m.slot + 1) % c.patlen;
        end else begin
          nx.valid = 1'b0;
        end
      end
    end
    return nx;
  endfunction

  initial begin
    logic [W-1:0] s;
    total = 0;
    bad   = 0;

    cfg[0] = '{mode:0, start:3, endv:6,    step:1, plen:4, patlen:3, pat:3, total:0};
    cfg[1] = '{mode:1, start:0, endv:10,   step:3, plen:4, patlen:4, pat:5, total:0};
    cfg[2] = '{mode:2, start:0, endv:0,    step:1, plen:0, patlen:1, pat:1, total:0};
    cfg[3] = '{mode:0, start:0, endv:1023, step:1, plen:0, patlen:1, pat:1, total:5};

    s = 10'd1;
    for (int i = 0; i < 4096; i++) begin
      lfsr_seq[i] = int'(s);
      s = {s[W-2:0], ^(s & 10'h240)};
    end

    for (int k = 0; k < NINST; k++) begin
      rst_v[k] = 1'b1;
      en_v[k]  = 1'b0;
      rdy_v[k] = 1'b0;
      mdl[k]   = mdl_reset();
    end

    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < NINST; k++) begin
        check_eq($sformatf("u%0d.valid c%0d", k, cyc), 64'(vld_v[k]), 64'(mdl[k].valid));
        check_eq($sformatf("u%0d.data c%0d", k, cyc), 64'(dat_v[k]),
                 64'(exp_data(cfg[k], mdl[k].n)));
        check_eq($sformatf("u%0d.done c%0d", k, cyc), 64'(dn_v[k]), 64'(mdl[k].phase == 2));
        check_eq($sformatf("u%0d.count c%0d", k, cyc), 64'(bc_v[k]), 64'(mdl[k].n));
        if (mdl[k].valid) begin
          check_eq($sformatf("u%0d.last c%0d", k, cyc), 64'(lst_v[k]),
                   64'(cfg[k].plen != 0 && (mdl[k].n % cfg[k].plen) == cfg[k].plen - 1));
          if (k == 2) begin
            check_eq($sformatf("u2.nonzero c%0d", cyc), 64'(dat_v[k] != '0), 64'd1);
          end
        end
      end

      for (int k = 0; k < NINST; k++) begin
        rst_v[k] = (cyc < 3) || (k == 2 && cyc == 1400) || (k == 3 && cyc == 800);
        en_v[k]  = ($urandom_range(0, 15) != 0);
        rdy_v[k] = (k == 2) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 3) != 0);
        mdl[k]   = mdl_step(cfg[k], mdl[k], rst_v[k], en_v[k], rdy_v[k]);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
